// File: rtl/req_ack_source_fifo_if.sv
// req_ack_source_fifo_if: push stream, pull handshake and status signals of the source FIFO
interface req_ack_source_fifo_if #(
    parameter int data_width = 32,
    parameter int depth_log2 = 3
);
    logic                  wr_en;
    logic [data_width-1:0] wr_data;
    logic                  full;
    logic                  req;
    logic                  ack;
    logic [data_width-1:0] dout;
    logic                  stall;
    logic [depth_log2:0]   level;
    logic [31:0]           count;

    modport master (
        output wr_en, wr_data, req, stall,
        input  full, ack, dout, level, count
    );

    modport slave (
        input  wr_en, wr_data, req, stall,
        output full, ack, dout, level, count
    );
endinterface

// File: rtl/req_ack_source_fifo.sv
// req_ack_source_fifo: FIFO fed by a push stream, drained one item per req with a pulsed ack
module req_ack_source_fifo #(
    parameter int                    data_width    = 32,
    parameter int                    depth_log2    = 3,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input logic               clk,
    input logic               rst,
    req_ack_source_fifo_if.slave bus
);
    localparam int depth = 1 << depth_log2;

    logic [data_width-1:0] mem [depth];
    logic [depth_log2-1:0] wr_ptr, rd_ptr;
    logic [depth_log2:0]   level_r, level_next;
    logic [data_width-1:0] dout_r;
    logic [31:0]           count_r;
    logic                  ack_r, full_r, push, serve;

    // full comes from the pre-edge level, so a same-edge serve never makes room for a push
    assign push       = bus.wr_en & ~full_r;
    assign serve      = bus.req & ~ack_r & ~bus.stall & (level_r != '0);
    assign level_next = level_r + (depth_log2 + 1)'(push) - (depth_log2 + 1)'(serve);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
            full_r  <= 1'b0;
            ack_r   <= 1'b0;
            dout_r  <= initial_value;
            count_r <= '0;
        end else begin
            level_r <= level_next;
            full_r  <= level_next == (depth_log2 + 1)'(depth);
            ack_r   <= serve;
            if (push) wr_ptr <= wr_ptr + depth_log2'(1);
            if (serve) begin
                rd_ptr  <= rd_ptr + depth_log2'(1);
                dout_r  <= mem[rd_ptr];
                count_r <= count_r + 32'd1;
            end
        end
    end

    assign bus.full  = full_r;
    assign bus.ack   = ack_r;
    assign bus.dout  = dout_r;
    assign bus.level = level_r;
    assign bus.count = count_r;
endmodule

// File: tb/tb_req_ack_source_fifo.sv
// tb_req_ack_source_fifo: directed checks of push, pull, back-pressure and async reset
module tb_req_ack_source_fifo;
    localparam logic [31:0] init_val = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int fails = 0;

    req_ack_source_fifo_if #(.data_width(32), .depth_log2(3)) bus ();

    req_ack_source_fifo #(
        .data_width(32),
        .depth_log2(3),
        .initial_value(init_val)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.req     = 1'b0;
        bus.stall   = 1'b0;
        #12;
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_dout", bus.dout, init_val);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_count", bus.count, 0);
        rst = 1'b0;
        @(negedge clk);

        // push 5,6,7 with req held high
        bus.req = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 5;
        tick(); chk("t1_ack_e1", 32'(bus.ack), 0); chk("t1_lvl_e1", 32'(bus.level), 1);
        bus.wr_data = 6;
        tick(); chk("t1_ack_e2", 32'(bus.ack), 1); chk("t1_dout5", bus.dout, 5);
        bus.wr_data = 7;
        tick(); chk("t1_ack_e3", 32'(bus.ack), 0); chk("t1_lvl_e3", 32'(bus.level), 2);
        bus.wr_en = 1'b0;
        tick(); chk("t1_ack_e4", 32'(bus.ack), 1); chk("t1_dout6", bus.dout, 6);
        tick(); chk("t1_ack_e5", 32'(bus.ack), 0); chk("t1_hold6", bus.dout, 6);
        tick(); chk("t1_ack_e6", 32'(bus.ack), 1); chk("t1_dout7", bus.dout, 7);
        chk("t1_count", bus.count, 3); chk("t1_lvl_end", 32'(bus.level), 0);
        bus.req = 1'b0;
        tick(); chk("t1_ack_e7", 32'(bus.ack), 0);

        // fill to full, drop a 9th push, then drain
        bus.wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.wr_data = 32'(i);
            tick();
        end
        chk("t2_full", 32'(bus.full), 1); chk("t2_lvl8", 32'(bus.level), 8);
        bus.wr_data = 99;
        tick(); chk("t2_drop_lvl", 32'(bus.level), 8); chk("t2_drop_ack", 32'(bus.ack), 0);
        bus.wr_en = 1'b0; bus.req = 1'b1;
        tick(); chk("t2_ack0", 32'(bus.ack), 1); chk("t2_dout0", bus.dout, 0);
        chk("t2_full_drop", 32'(bus.full), 0); chk("t2_lvl7", 32'(bus.level), 7);
        for (int i = 1; i < 8; i++) begin
            tick(); chk("t2_gap", 32'(bus.ack), 0);
            tick(); chk("t2_ack", 32'(bus.ack), 1); chk("t2_dout", bus.dout, 32'(i));
        end
        chk("t2_lvl_end", 32'(bus.level), 0); chk("t2_count", bus.count, 11);
        tick(); chk("t2_no99_ack", 32'(bus.ack), 0);
        tick(); chk("t2_no99_ack2", 32'(bus.ack), 0); chk("t2_no99_dout", bus.dout, 7);

        // empty with req high: push at E, ack only after E+1
        bus.wr_en = 1'b1; bus.wr_data = 42;
        tick(); chk("t3_ack_E", 32'(bus.ack), 0); chk("t3_lvl_E", 32'(bus.level), 1);
        bus.wr_en = 1'b0;
        tick(); chk("t3_ack_E1", 32'(bus.ack), 1); chk("t3_dout", bus.dout, 42);
        bus.req = 1'b0;
        tick(); chk("t3_ack_off", 32'(bus.ack), 0);

        // full: push and serve on the same edge drops the push
        bus.wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.wr_data = 32'(10 + i);
            tick();
        end
        chk("t4_full", 32'(bus.full), 1);
        bus.wr_data = 77; bus.req = 1'b1;
        tick(); chk("t4_ack", 32'(bus.ack), 1); chk("t4_dout", bus.dout, 10);
        chk("t4_lvl7", 32'(bus.level), 7); chk("t4_full_off", 32'(bus.full), 0);
        bus.wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk("t4_gap", 32'(bus.ack), 0);
            tick(); chk("t4_drain", bus.dout, 32'(11 + i));
        end
        chk("t4_lvl3", 32'(bus.level), 3);

        // stall blocks service for 10 cycles
        bus.stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); chk("t5_stall_ack", 32'(bus.ack), 0);
        end
        chk("t5_stall_dout", bus.dout, 14); chk("t5_stall_lvl", 32'(bus.level), 3);
        bus.stall = 1'b0;
        tick(); chk("t5_resume_ack", 32'(bus.ack), 1); chk("t5_resume_dout", bus.dout, 15);

        // build level 4 with ack high, then async reset
        bus.req = 1'b0; bus.wr_en = 1'b1; bus.wr_data = 20;
        tick();
        bus.wr_data = 21;
        tick(); chk("t6_lvl4", 32'(bus.level), 4);
        bus.wr_data = 22; bus.req = 1'b1;
        tick(); chk("t6_ack", 32'(bus.ack), 1); chk("t6_dout", bus.dout, 16);
        chk("t6_lvl_same", 32'(bus.level), 4); chk("t6_count", bus.count, 19);
        bus.wr_en = 1'b0; bus.req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ack", 32'(bus.ack), 0); chk("t6_rst_lvl", 32'(bus.level), 0);
        chk("t6_rst_count", bus.count, 0); chk("t6_rst_dout", bus.dout, init_val);
        chk("t6_rst_full", 32'(bus.full), 0);
        #1 rst = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 55; bus.req = 1'b1;
        tick(); chk("t6_post_ack0", 32'(bus.ack), 0); chk("t6_post_lvl", 32'(bus.level), 1);
        bus.wr_en = 1'b0;
        tick(); chk("t6_post_ack", 32'(bus.ack), 1); chk("t6_post_dout", bus.dout, 55);
        chk("t6_post_count", bus.count, 1);
        tick(); chk("t6_post_gap", 32'(bus.ack), 0); chk("t6_post_empty", 32'(bus.level), 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/req_ack_source_fifo.md
Name: req_ack_source_fifo

Overview:
- Synthesizable responder end of the req/ack pull handshake used by every async_operator left port (`req_l`/`ack_l`/`din`).
- Takes a push stream (write enable / full) into an internal FIFO and serves items one per request: a pulsed `ack`, with data held on `dout`.
- Replaces the behavioural producer at `arf` inputs when the graph is fed by real logic instead of a testbench.

Parameters:
- data_width, 32, width of stored items and dout
- depth_log2, 3, FIFO depth is 2**depth_log2 entries (min 1)
- initial_value, 0, value driven on dout after reset until first served item

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  asynchronous active-high reset
- wr_en  input  1  push request from upstream logic
- wr_data  input  data_width  item to push
- full  output  1  FIFO holds 2**depth_log2 items; pushes ignored
- req  input  1  pull request from downstream requester (async_operator req_l)
- ack  output  1  single-cycle pulse: item delivered on dout
- dout  output  data_width  delivered item, stable from ack rise until next ack rise
- stall  input  1  when high, no new ack is issued (back-pressure / fault injection)
- level  output  depth_log2+1  number of stored items, 0..2**depth_log2
- count  output  32  total items delivered since reset

Behaviour:
- Reset (async, rst=1): ack=0, dout=initial_value, level=0, full=0, count=0, read/write pointers=0. FIFO contents are discarded; a reset mid-transfer drops all items and any pending ack.
- Push: at posedge, if wr_en & ~full, store wr_data at write pointer and advance it (wrap modulo depth). If wr_en & full, nothing is stored, no error flag, state unchanged.
- Serve condition at posedge: req & ~ack & ~stall & (level!=0). When it holds:
  - ack<=1, dout<=head item, read pointer advances (wrap), count<=count+1.
  - Otherwise ack<=0 and dout holds.
- ack is never high two consecutive cycles. The ~ack term guarantees a requester that drops req one cycle after seeing ack is not served twice.
- Max rate is one item per 2 cycles.
- dout changes only on edges where ack rises. Requesters latch on posedge ack, so dout must be registered on the same edge and never glitch afterwards.
- No bypass: an item pushed at edge E is first eligible at edge E+1, so ack is high at the earliest after edge E+1. This is a minimum 1-cycle latency from push to ack, and holds even when the FIFO is empty and req is high.
- Simultaneous push and serve in one edge: both occur, level unchanged.
- When full, a serve on the same edge does not free space for that edge's push. full is evaluated from the pre-edge level, so that push is dropped.
- level and full are registered and updated on the same edge as the push or serve. full = (level == 2**depth_log2).
- stall sampled at the edge: stall=1 blocks ack regardless of req/level. Deasserting stall resumes service at the next edge.
- req deasserted before service: no ack; the item stays queued.
- count wraps from 2**32-1 to 0.
- Pointer width is depth_log2 with natural wrap. Full/empty are derived from level, not pointer comparison.

Test Plan:
- Reset then push 5,6,7 (one per cycle), req held high by async_operator-style requester -> acks with dout 5,6,7 in order, ack never high 2 cycles running, count=3, level ends 0.
- Push 8 items (depth_log2=3) with req=0 -> full=1, level=8; a 9th push of 99 is dropped; then pull 8 -> values 0..7, 99 never appears, full drops after first ack.
- Empty FIFO, req=1, push 42 at edge E -> ack=1 only after edge E+1, dout=42; no earlier ack.
- Full FIFO, push and serve on the same edge -> pushed item dropped, level=7 after edge; served item correct.
- stall=1 for 10 cycles with level=3 and req=1 -> no ack, dout unchanged; stall=0 -> ack next edge with head item.
- Assert rst asynchronously mid-stream with level=4 and ack=1 -> ack, level, count drop to 0 immediately; dout=initial_value; next push/pull serves only post-reset data.
